seq_mul_add: RTL and testbench

- Sequential shift-and-add multiplier with an accumulate input. It computes product = multiplicand * multiplier + addend, one multiplier bit per clock.
- It is the inverse companion of the team's sequential divider: it rebuilds dividend = quotient * divisor + remainder. It is used on the datapath and in self-check loops that feed divider outputs back in.
- Start/busy/done handshake, fixed latency, unsigned operands.

---
 rtl/seq_mul_add.sv | 101 ++++++++++
 tb/tb_seq_mul_add.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_add.sv
// Sequential shift-and-add multiplier with accumulate input.
// Computes product = multiplicand * multiplier + addend (unsigned), one multiplier bit
// per clock, LSB first. Latency is fixed: M RUN edges after the accepting edge.
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_ni          asynchronous active-low reset
//   start_i         request, sampled only while idle
//   multiplicand_i  operand A (M bits), captured on the accepting edge
//   multiplier_i    operand B (M bits), captured on the accepting edge
//   addend_i        operand C (M bits), captured on the accepting edge
//   busy_o          high while a computation is running
//   done_o          one-cycle pulse, product_o valid in this cycle
//   product_o       A*B + C (2*M bits), held until the next completion
module seq_mul_add #(
    parameter int unsigned M = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [M-1:0]     multiplicand_i,
    input  logic [M-1:0]     multiplier_i,
    input  logic [M-1:0]     addend_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [2*M-1:0]   product_o
);

    localparam int unsigned CW = $clog2(M + 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [2*M-1:0]   a_q, a_d;      // multiplicand, pre-shifted to the current step weight
    logic [M-1:0]     b_q, b_d;      // multiplier, consumed LSB first
    logic [2*M-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*M-1:0]   prod_q, prod_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    a_d     = {{M{1'b0}}, multiplicand_i};
                    b_d     = multiplier_i;
                    acc_d   = {{M{1'b0}}, addend_i};
                    cnt_d   = CW'(M);
                end
            end
            StRun: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CW'(1);
                // Last step: publish the accumulator including this step's partial product.
                if (cnt_q == CW'(1)) begin
                    prod_d  = acc_d;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign busy_o    = (state_q == StRun);
    assign done_o    = done_q;
    assign product_o = prod_q;

endmodule

// File: tb/tb_seq_mul_add.sv
// Bench for seq_mul_add: one instance at M=32 and one at M=8 sharing clock and reset.
// Expected products come from plain integer arithmetic (A*B + C, q*d + r).
module tb_seq_mul_add;

    logic        clk;
    logic        rst_n;

    logic        start32, busy32, done32;
    logic [31:0] a32, b32, c32;
    logic [63:0] prod32;

    logic        start8, busy8, done8;
    logic [7:0]  a8, b8, c8;
    logic [15:0] prod8;

    int n_total;
    int n_bad;

    seq_mul_add #(.M(32)) dut32 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start32),
        .multiplicand_i (a32),
        .multiplier_i   (b32),
        .addend_i       (c32),
        .busy_o         (busy32),
        .done_o         (done32),
        .product_o      (prod32)
    );

    seq_mul_add #(.M(8)) dut8 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start8),
        .multiplicand_i (a8),
        .multiplier_i   (b8),
        .addend_i       (c8),
        .busy_o         (busy8),
        .done_o         (done8),
        .product_o      (prod8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit w8, input logic st, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c);
        if (w8) begin
            start8 = st; a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0];
        end else begin
            start32 = st; a32 = a[31:0]; b32 = b[31:0]; c32 = c[31:0];
        end
    endtask

    function automatic logic get_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction

    function automatic logic get_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction

    function automatic logic [63:0] get_prod(input bit w8);
        return w8 ? {48'd0, prod8} : prod32;
    endfunction

    // One full transaction: latency, single done, busy profile, product stability and value.
    task automatic op(input bit w8, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input int m, input string tag);
        logic [63:0] exp, p0, pd;
        int first, ndone, bbad, pchg;
        exp = a * b + c;
        drive(w8, 1'b1, a, b, c);
        @(posedge clk); #1;
        drive(w8, 1'b0, 64'($urandom), 64'($urandom), 64'($urandom));
        first = -1; ndone = 0; bbad = 0; pchg = 0; pd = '0;
        p0 = get_prod(w8);
        for (int k = 0; k <= m + 3; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (get_busy(w8) !== (k < m)) bbad++;
            if (k < m && get_prod(w8) !== p0) pchg++;
            if (get_done(w8) === 1'b1) begin
                ndone++;
                if (first < 0) first = k;
                pd = get_prod(w8);
            end
        end
        check_eq({tag, " latency"}, 64'(first), 64'(m));
        check_eq({tag, " done_count"}, 64'(ndone), 64'd1);
        check_eq({tag, " busy_profile"}, 64'(bbad), 64'd0);
        check_eq({tag, " product_stable_in_run"}, 64'(pchg), 64'd0);
        check_eq({tag, " product_at_done"}, pd, exp);
        check_eq({tag, " product_held"}, get_prod(w8), exp);
    endtask

    initial begin
        int first, ndone, bad_idle;
        int dk[4];
        logic [63:0] dp[4];
        logic [63:0] pd, q, d, r;

        n_total = 0;
        n_bad   = 0;

        // Reset with start asserted: everything stays cleared.
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 64'($urandom), 64'($urandom), 64'($urandom));
        drive(1'b1, 1'b1, 64'($urandom), 64'($urandom), 64'($urandom));
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset busy32", 64'(busy32), 64'd0);
        check_eq("reset done32", 64'(done32), 64'd0);
        check_eq("reset prod32", prod32, 64'd0);
        check_eq("reset busy8", 64'(busy8), 64'd0);
        check_eq("reset prod8", 64'(prod8), 64'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        drive(1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
        bad_idle = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (busy32 !== 1'b0 || done32 !== 1'b0 || prod32 !== 64'd0) bad_idle++;
            if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'd0) bad_idle++;
        end
        check_eq("idle_after_reset", 64'(bad_idle), 64'd0);

        op(1'b0, 64'd7, 64'd6, 64'd3, 32, "basic32");
        op(1'b1, 64'd255, 64'd255, 64'd255, 8, "max8");
        op(1'b1, 64'd0, 64'd0, 64'd0, 8, "zero8");
        for (int i = 0; i < 40; i++) begin
            op(1'b1, 64'($urandom_range(255)), 64'($urandom_range(255)),
               64'($urandom_range(255)), 8, "rand8");
        end

        // Start pulse while busy must be ignored.
        drive(1'b1, 1'b1, 64'd10, 64'd10, 64'd0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 64'd10, 64'd10, 64'd0);
        first = -1; ndone = 0; pd = '0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                ndone++;
                if (first < 0) first = k;
                pd = {48'd0, prod8};
            end
            if (k == 2) drive(1'b1, 1'b1, 64'd1, 64'd1, 64'd0);
            if (k == 3) drive(1'b1, 1'b0, 64'd1, 64'd1, 64'd0);
        end
        check_eq("ignore_start latency", 64'(first), 64'd8);
        check_eq("ignore_start done_count", 64'(ndone), 64'd1);
        check_eq("ignore_start product", pd, 64'd100);

        // Back-to-back with start held high.
        drive(1'b1, 1'b1, 64'd3, 64'd4, 64'd1);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 64'd12, 64'd12, 64'd5);
        ndone = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                if (ndone < 4) begin
                    dk[ndone] = k;
                    dp[ndone] = {48'd0, prod8};
                end
                ndone++;
            end
            if (k == 9) drive(1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
        end
        check_eq("b2b done_count", 64'(ndone), 64'd2);
        if (ndone >= 2) begin
            check_eq("b2b first_edge", 64'(dk[0]), 64'd8);
            check_eq("b2b first_product", dp[0], 64'd13);
            check_eq("b2b second_edge", 64'(dk[1]), 64'd17);
            check_eq("b2b second_product", dp[1], 64'd149);
        end

        // Reset in the middle of a run: aborted, no done, product cleared.
        drive(1'b0, 1'b1, 64'($urandom), 64'($urandom), 64'($urandom));
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check_eq("midreset busy_before", 64'(busy32), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midreset busy", 64'(busy32), 64'd0);
        check_eq("midreset done", 64'(done32), 64'd0);
        check_eq("midreset product", prod32, 64'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 2) rst_n = 1'b1;
            if (done32 === 1'b1) ndone++;
        end
        check_eq("midreset no_done", 64'(ndone), 64'd0);
        check_eq("midreset product_after", prod32, 64'd0);

        // Divider round trip: dividend = q * d + r with r < d.
        for (int i = 0; i < 1000; i++) begin
            q = 64'($urandom);
            d = 64'($urandom);
            if (d == 64'd0) d = 64'd1;
            r = 64'($urandom) % d;
            op(1'b0, q, d, r, 32, "roundtrip");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
